// File: rtl/sc_regshifter_flags_if.sv
// -----------------------------------------------------------------------------
// sc_regshifter_flags_if
// Bus bundle between the control/ALU side and the register-shifter stage.
//   master : drives ALU result, ALU carry/overflow, clear/load strobes and
//            shift selection; observes stored value, flags and shift count.
//   slave  : the register-shifter itself (mirror of master).
// All strobes and flags with the _InLow/_OutLow suffix are active low.
// -----------------------------------------------------------------------------
interface sc_regshifter_flags_if #(
  parameter int unsigned DATAWIDTH_BUS                  = 8,
  parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int unsigned DATAWIDTH_SHIFTCOUNT           = 4
);

  // Request side (ALU / state machine -> register-shifter)
  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_data_InBUS;
  logic                                      SC_REGSHIFTER_carry_InLow;
  logic                                      SC_REGSHIFTER_overflow_InLow;
  logic                                      SC_REGSHIFTER_clear_InLow;
  logic                                      SC_REGSHIFTER_load_InLow;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_REGSHIFTER_shiftselection_In;

  // Result side (register-shifter -> BUSC / state machine flag inputs)
  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_data_OutBUS;
  logic                                      SC_REGSHIFTER_overflow_OutLow;
  logic                                      SC_REGSHIFTER_carry_OutLow;
  logic                                      SC_REGSHIFTER_negative_OutLow;
  logic                                      SC_REGSHIFTER_zero_OutLow;
  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_REGSHIFTER_shiftcount_OutBUS;

  modport master (
    output SC_REGSHIFTER_data_InBUS,
    output SC_REGSHIFTER_carry_InLow,
    output SC_REGSHIFTER_overflow_InLow,
    output SC_REGSHIFTER_clear_InLow,
    output SC_REGSHIFTER_load_InLow,
    output SC_REGSHIFTER_shiftselection_In,
    input  SC_REGSHIFTER_data_OutBUS,
    input  SC_REGSHIFTER_overflow_OutLow,
    input  SC_REGSHIFTER_carry_OutLow,
    input  SC_REGSHIFTER_negative_OutLow,
    input  SC_REGSHIFTER_zero_OutLow,
    input  SC_REGSHIFTER_shiftcount_OutBUS
  );

  modport slave (
    input  SC_REGSHIFTER_data_InBUS,
    input  SC_REGSHIFTER_carry_InLow,
    input  SC_REGSHIFTER_overflow_InLow,
    input  SC_REGSHIFTER_clear_InLow,
    input  SC_REGSHIFTER_load_InLow,
    input  SC_REGSHIFTER_shiftselection_In,
    output SC_REGSHIFTER_data_OutBUS,
    output SC_REGSHIFTER_overflow_OutLow,
    output SC_REGSHIFTER_carry_OutLow,
    output SC_REGSHIFTER_negative_OutLow,
    output SC_REGSHIFTER_zero_OutLow,
    output SC_REGSHIFTER_shiftcount_OutBUS
  );

endinterface

// File: rtl/sc_regshifter_flags.sv
// -----------------------------------------------------------------------------
// sc_regshifter_flags
// Register-shifter stage downstream of the ALU. Captures the ALU result on a
// load strobe, performs single-bit logical left/right shifts, drives the
// stored value onto BUSC and keeps active-low overflow/carry/negative/zero
// flags plus a saturating shift counter.
//
// Ports:
//   SC_REGSHIFTER_CLOCK_50      : clock, all state on the rising edge
//   SC_REGSHIFTER_RESET_InHigh  : synchronous reset, active high
//   regshifter_bus (slave)      : ALU result, carry/overflow in, clear/load
//                                 strobes, shift selection; stored value,
//                                 flags and shift count out
//
// Per-edge priority: reset > clear > load > shift > hold. All outputs are
// registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module sc_regshifter_flags #(
  parameter int unsigned DATAWIDTH_BUS                  = 8,
  parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int unsigned DATAWIDTH_SHIFTCOUNT           = 4
) (
  input  logic                SC_REGSHIFTER_CLOCK_50,
  input  logic                SC_REGSHIFTER_RESET_InHigh,
  sc_regshifter_flags_if.slave regshifter_bus
);

  localparam int unsigned W    = DATAWIDTH_BUS;
  localparam int unsigned SELW = DATAWIDTH_REGSHIFTER_SELECTION;
  localparam int unsigned CNTW = DATAWIDTH_SHIFTCOUNT;

  localparam logic [SELW-1:0] SEL_LEFT  = SELW'(1);
  localparam logic [SELW-1:0] SEL_RIGHT = SELW'(2);
  localparam logic [CNTW-1:0] COUNT_MAX = {CNTW{1'b1}};

  // One action wins per edge; everything below it is discarded.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_SHIFT_LEFT,
    ACT_SHIFT_RIGHT
  } action_e;

  action_e         action_c;

  logic [W-1:0]    data_q,     data_d;
  logic            carry_q,    carry_d;
  logic            overflow_q, overflow_d;
  logic            negative_q, negative_d;
  logic            zero_q,     zero_d;
  logic [CNTW-1:0] count_q,    count_d;

  // Priority decode of the request strobes (reset is handled in the register).
  always_comb begin
    action_c = ACT_HOLD;
    if (!regshifter_bus.SC_REGSHIFTER_clear_InLow) begin
      action_c = ACT_CLEAR;
    end else if (!regshifter_bus.SC_REGSHIFTER_load_InLow) begin
      action_c = ACT_LOAD;
    end else if (regshifter_bus.SC_REGSHIFTER_shiftselection_In == SEL_LEFT) begin
      action_c = ACT_SHIFT_LEFT;
    end else if (regshifter_bus.SC_REGSHIFTER_shiftselection_In == SEL_RIGHT) begin
      action_c = ACT_SHIFT_RIGHT;
    end
  end

  // Next-state datapath and flag computation.
  always_comb begin
    data_d     = data_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    count_d    = count_q;

    case (action_c)
      ACT_CLEAR: begin
        data_d     = '0;
        carry_d    = 1'b1;
        overflow_d = 1'b1;
        count_d    = '0;
      end
      ACT_LOAD: begin
        data_d     = regshifter_bus.SC_REGSHIFTER_data_InBUS;
        carry_d    = regshifter_bus.SC_REGSHIFTER_carry_InLow;
        overflow_d = regshifter_bus.SC_REGSHIFTER_overflow_InLow;
        count_d    = '0;
      end
      ACT_SHIFT_LEFT: begin
        data_d     = {data_q[W-2:0], 1'b0};
        carry_d    = ~data_q[W-1];
        // Sign bit changes when the top two bits differ before the shift.
        overflow_d = ~(data_q[W-1] ^ data_q[W-2]);
        count_d    = (count_q == COUNT_MAX) ? count_q : count_q + CNTW'(1);
      end
      ACT_SHIFT_RIGHT: begin
        data_d     = {1'b0, data_q[W-1:1]};
        carry_d    = ~data_q[0];
        overflow_d = 1'b1;
        count_d    = (count_q == COUNT_MAX) ? count_q : count_q + CNTW'(1);
      end
      default: begin
      end
    endcase

    // Negative/zero track the new value on every non-hold action.
    if (action_c != ACT_HOLD) begin
      negative_d = ~data_d[W-1];
      zero_d     = ~(data_d == '0);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge SC_REGSHIFTER_CLOCK_50) begin
    if (SC_REGSHIFTER_RESET_InHigh) begin
      data_q     <= '0;
      carry_q    <= 1'b1;
      overflow_q <= 1'b1;
      negative_q <= 1'b1;
      zero_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      data_q     <= data_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
      zero_q     <= zero_d;
      count_q    <= count_d;
    end
  end

  assign regshifter_bus.SC_REGSHIFTER_data_OutBUS       = data_q;
  assign regshifter_bus.SC_REGSHIFTER_carry_OutLow      = carry_q;
  assign regshifter_bus.SC_REGSHIFTER_overflow_OutLow   = overflow_q;
  assign regshifter_bus.SC_REGSHIFTER_negative_OutLow   = negative_q;
  assign regshifter_bus.SC_REGSHIFTER_zero_OutLow       = zero_q;
  assign regshifter_bus.SC_REGSHIFTER_shiftcount_OutBUS = count_q;

endmodule

// File: tb/tb_sc_regshifter_flags.sv
// -----------------------------------------------------------------------------
// tb_sc_regshifter_flags
// Directed self-checking bench for sc_regshifter_flags. Inputs change 1 ns
// after a rising edge; outputs are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_regshifter_flags;

  logic SC_REGSHIFTER_CLOCK_50;
  logic SC_REGSHIFTER_RESET_InHigh;

  int n_checks;
  int n_fails;

  sc_regshifter_flags_if #(
    .DATAWIDTH_BUS(8),
    .DATAWIDTH_REGSHIFTER_SELECTION(2),
    .DATAWIDTH_SHIFTCOUNT(4)
  ) bus_if ();

  sc_regshifter_flags #(
    .DATAWIDTH_BUS(8),
    .DATAWIDTH_REGSHIFTER_SELECTION(2),
    .DATAWIDTH_SHIFTCOUNT(4)
  ) dut (
    .SC_REGSHIFTER_CLOCK_50    (SC_REGSHIFTER_CLOCK_50),
    .SC_REGSHIFTER_RESET_InHigh(SC_REGSHIFTER_RESET_InHigh),
    .regshifter_bus            (bus_if)
  );

  initial SC_REGSHIFTER_CLOCK_50 = 1'b0;
  always #10 SC_REGSHIFTER_CLOCK_50 = ~SC_REGSHIFTER_CLOCK_50;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge SC_REGSHIFTER_CLOCK_50);
    #1;
  endtask

  task automatic idle_inputs();
    SC_REGSHIFTER_RESET_InHigh             = 1'b0;
    bus_if.SC_REGSHIFTER_clear_InLow       = 1'b1;
    bus_if.SC_REGSHIFTER_load_InLow        = 1'b1;
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b00;
    bus_if.SC_REGSHIFTER_carry_InLow       = 1'b1;
    bus_if.SC_REGSHIFTER_overflow_InLow    = 1'b1;
    bus_if.SC_REGSHIFTER_data_InBUS        = 8'h00;
  endtask

  task automatic load_value(input logic [7:0] v, input logic c, input logic o);
    idle_inputs();
    bus_if.SC_REGSHIFTER_data_InBUS     = v;
    bus_if.SC_REGSHIFTER_carry_InLow    = c;
    bus_if.SC_REGSHIFTER_overflow_InLow = o;
    bus_if.SC_REGSHIFTER_load_InLow     = 1'b0;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus_if.SC_REGSHIFTER_data_InBUS = 8'hA5;
    bus_if.SC_REGSHIFTER_load_InLow = 1'b0;
    SC_REGSHIFTER_RESET_InHigh      = 1'b1;
    step();
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h00) begin n_fails++; $display("FAIL reset_data: got %h expected 00", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b0) begin n_fails++; $display("FAIL reset_zero: got %b expected 0", bus_if.SC_REGSHIFTER_zero_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_negative_OutLow !== 1'b1) begin n_fails++; $display("FAIL reset_negative: got %b expected 1", bus_if.SC_REGSHIFTER_negative_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL reset_carry: got %b expected 1", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b1) begin n_fails++; $display("FAIL reset_overflow: got %b expected 1", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd0) begin n_fails++; $display("FAIL reset_count: got %0d expected 0", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
  endtask

  task automatic test_load();
    load_value(8'h85, 1'b0, 1'b1);
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h85) begin n_fails++; $display("FAIL load_data: got %h expected 85", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_negative_OutLow !== 1'b0) begin n_fails++; $display("FAIL load_negative: got %b expected 0", bus_if.SC_REGSHIFTER_negative_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b1) begin n_fails++; $display("FAIL load_zero: got %b expected 1", bus_if.SC_REGSHIFTER_zero_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b0) begin n_fails++; $display("FAIL load_carry: got %b expected 0", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b1) begin n_fails++; $display("FAIL load_overflow: got %b expected 1", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd0) begin n_fails++; $display("FAIL load_count: got %0d expected 0", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
  endtask

  // Continues from 0x85 left by test_load.
  task automatic test_shift_left();
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b01;
    step();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h0A) begin n_fails++; $display("FAIL shl1_data: got %h expected 0a", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b0) begin n_fails++; $display("FAIL shl1_carry: got %b expected 0", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b0) begin n_fails++; $display("FAIL shl1_overflow: got %b expected 0", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_negative_OutLow !== 1'b1) begin n_fails++; $display("FAIL shl1_negative: got %b expected 1", bus_if.SC_REGSHIFTER_negative_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd1) begin n_fails++; $display("FAIL shl1_count: got %0d expected 1", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    step();
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h14) begin n_fails++; $display("FAIL shl2_data: got %h expected 14", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL shl2_carry: got %b expected 1", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b1) begin n_fails++; $display("FAIL shl2_overflow: got %b expected 1", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b1) begin n_fails++; $display("FAIL shl2_zero: got %b expected 1", bus_if.SC_REGSHIFTER_zero_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd2) begin n_fails++; $display("FAIL shl2_count: got %0d expected 2", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
  endtask

  task automatic test_shift_right();
    load_value(8'h01, 1'b1, 1'b0);
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b10;
    step();
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h00) begin n_fails++; $display("FAIL shr_data: got %h expected 00", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b0) begin n_fails++; $display("FAIL shr_carry: got %b expected 0", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b0) begin n_fails++; $display("FAIL shr_zero: got %b expected 0", bus_if.SC_REGSHIFTER_zero_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b1) begin n_fails++; $display("FAIL shr_overflow: got %b expected 1", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd1) begin n_fails++; $display("FAIL shr_count: got %0d expected 1", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    // Logical shift: MSB of 0x80 must not be replicated.
    load_value(8'h80, 1'b1, 1'b1);
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b10;
    step();
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h40) begin n_fails++; $display("FAIL shr_msb_data: got %h expected 40", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_negative_OutLow !== 1'b1) begin n_fails++; $display("FAIL shr_msb_negative: got %b expected 1", bus_if.SC_REGSHIFTER_negative_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL shr_msb_carry: got %b expected 1", bus_if.SC_REGSHIFTER_carry_OutLow); end
  endtask

  task automatic test_priority();
    load_value(8'h33, 1'b0, 1'b0);
    bus_if.SC_REGSHIFTER_clear_InLow       = 1'b0;
    bus_if.SC_REGSHIFTER_load_InLow        = 1'b0;
    bus_if.SC_REGSHIFTER_data_InBUS        = 8'h55;
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b01;
    step();
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h00) begin n_fails++; $display("FAIL prio_clear_data: got %h expected 00", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b0) begin n_fails++; $display("FAIL prio_clear_zero: got %b expected 0", bus_if.SC_REGSHIFTER_zero_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL prio_clear_carry: got %b expected 1", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b1) begin n_fails++; $display("FAIL prio_clear_overflow: got %b expected 1", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd0) begin n_fails++; $display("FAIL prio_clear_count: got %0d expected 0", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    // Load beats shift.
    bus_if.SC_REGSHIFTER_load_InLow        = 1'b0;
    bus_if.SC_REGSHIFTER_data_InBUS        = 8'h55;
    bus_if.SC_REGSHIFTER_carry_InLow       = 1'b1;
    bus_if.SC_REGSHIFTER_overflow_InLow    = 1'b0;
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b01;
    step();
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h55) begin n_fails++; $display("FAIL prio_load_data: got %h expected 55", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd0) begin n_fails++; $display("FAIL prio_load_count: got %0d expected 0", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b0) begin n_fails++; $display("FAIL prio_load_overflow: got %b expected 0", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL prio_load_carry: got %b expected 1", bus_if.SC_REGSHIFTER_carry_OutLow); end
  endtask

  // From 0x55: one left shift to 0xAA, then both hold codes.
  task automatic test_hold();
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b01;
    step();
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b0) begin n_fails++; $display("FAIL hold_pre_overflow: got %b expected 0", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    for (int k = 0; k < 2; k++) begin
      bus_if.SC_REGSHIFTER_shiftselection_In = (k == 0) ? 2'b00 : 2'b11;
      step();
      n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'hAA) begin n_fails++; $display("FAIL hold_data[%0d]: got %h expected aa", k, bus_if.SC_REGSHIFTER_data_OutBUS); end
      n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd1) begin n_fails++; $display("FAIL hold_count[%0d]: got %0d expected 1", k, bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
      n_checks++; if (bus_if.SC_REGSHIFTER_negative_OutLow !== 1'b0) begin n_fails++; $display("FAIL hold_negative[%0d]: got %b expected 0", k, bus_if.SC_REGSHIFTER_negative_OutLow); end
      n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b0) begin n_fails++; $display("FAIL hold_overflow[%0d]: got %b expected 0", k, bus_if.SC_REGSHIFTER_overflow_OutLow); end
      n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL hold_carry[%0d]: got %b expected 1", k, bus_if.SC_REGSHIFTER_carry_OutLow); end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    logic [7:0] exp_data;
    logic [3:0] exp_count;
    load_value(8'hFF, 1'b1, 1'b1);
    exp_data  = 8'hFF;
    exp_count = 4'd0;
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_data = {exp_data[6:0], 1'b0};
      if (exp_count != 4'd15) exp_count = exp_count + 4'd1;
      n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== exp_data) begin n_fails++; $display("FAIL sat_data[%0d]: got %h expected %h", k, bus_if.SC_REGSHIFTER_data_OutBUS, exp_data); end
      n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== exp_count) begin n_fails++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, bus_if.SC_REGSHIFTER_shiftcount_OutBUS, exp_count); end
    end
    idle_inputs();
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd15) begin n_fails++; $display("FAIL sat_final_count: got %0d expected 15", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b0) begin n_fails++; $display("FAIL sat_final_zero: got %b expected 0", bus_if.SC_REGSHIFTER_zero_OutLow); end
  endtask

  task automatic test_reset_mid();
    load_value(8'hFF, 1'b0, 1'b0);
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b01;
    step();
    step();
    step();
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'hF8) begin n_fails++; $display("FAIL rmid_pre_data: got %h expected f8", bus_if.SC_REGSHIFTER_data_OutBUS); end
    SC_REGSHIFTER_RESET_InHigh = 1'b1;
    step();
    SC_REGSHIFTER_RESET_InHigh = 1'b0;
    n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h00) begin n_fails++; $display("FAIL rmid_data: got %h expected 00", bus_if.SC_REGSHIFTER_data_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd0) begin n_fails++; $display("FAIL rmid_count: got %0d expected 0", bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    n_checks++; if (bus_if.SC_REGSHIFTER_zero_OutLow !== 1'b0) begin n_fails++; $display("FAIL rmid_zero: got %b expected 0", bus_if.SC_REGSHIFTER_zero_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_negative_OutLow !== 1'b1) begin n_fails++; $display("FAIL rmid_negative: got %b expected 1", bus_if.SC_REGSHIFTER_negative_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== 1'b1) begin n_fails++; $display("FAIL rmid_carry: got %b expected 1", bus_if.SC_REGSHIFTER_carry_OutLow); end
    n_checks++; if (bus_if.SC_REGSHIFTER_overflow_OutLow !== 1'b1) begin n_fails++; $display("FAIL rmid_overflow: got %b expected 1", bus_if.SC_REGSHIFTER_overflow_OutLow); end
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== 8'h00) begin n_fails++; $display("FAIL rmid_hold_data[%0d]: got %h expected 00", k, bus_if.SC_REGSHIFTER_data_OutBUS); end
      n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'd0) begin n_fails++; $display("FAIL rmid_hold_count[%0d]: got %0d expected 0", k, bus_if.SC_REGSHIFTER_shiftcount_OutBUS); end
    end
    idle_inputs();
  endtask

  // Load followed immediately by consecutive right shifts.
  task automatic test_back_to_back();
    logic [7:0] exp_data [3];
    logic       exp_carry [3];
    exp_data[0] = 8'h1E; exp_carry[0] = 1'b1;
    exp_data[1] = 8'h0F; exp_carry[1] = 1'b1;
    exp_data[2] = 8'h07; exp_carry[2] = 1'b0;
    load_value(8'h3C, 1'b0, 1'b0);
    bus_if.SC_REGSHIFTER_shiftselection_In = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (bus_if.SC_REGSHIFTER_data_OutBUS !== exp_data[k]) begin n_fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, bus_if.SC_REGSHIFTER_data_OutBUS, exp_data[k]); end
      n_checks++; if (bus_if.SC_REGSHIFTER_carry_OutLow !== exp_carry[k]) begin n_fails++; $display("FAIL b2b_carry[%0d]: got %b expected %b", k, bus_if.SC_REGSHIFTER_carry_OutLow, exp_carry[k]); end
      n_checks++; if (bus_if.SC_REGSHIFTER_shiftcount_OutBUS !== 4'(k + 1)) begin n_fails++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, bus_if.SC_REGSHIFTER_shiftcount_OutBUS, k + 1); end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    SC_REGSHIFTER_RESET_InHigh = 1'b1;
    step();
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_priority();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
